// File: rtl/ct_sysio_mcore.sv
// System I/O block between the pads, CIU, L2C, CLINT/PLIC and the per-core PIUs.
// Every register is sampled on the AXI-master strobe; adds the L2 flush handshake, guarded time and low-power counters.
module ct_sysio_mcore #(
    parameter int CORE_NUM = 4,
    parameter int CNT_W    = 64,
    parameter int APB_HI   = 13
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    axim_clk_en,
    input  logic [CNT_W-1:0]        pad_cpu_sys_cnt,
    input  logic [39:0]             pad_cpu_apb_base,
    input  logic                    pad_cpu_l2cache_flush_req,
    input  logic                    l2c_sysio_flush_done,
    input  logic                    l2c_sysio_flush_idle,
    input  logic                    ciu_xx_no_op,
    input  logic [CORE_NUM-1:0]     clint_ms_int,
    input  logic [CORE_NUM-1:0]     clint_mt_int,
    input  logic [CORE_NUM-1:0]     clint_ss_int,
    input  logic [CORE_NUM-1:0]     clint_st_int,
    input  logic [CORE_NUM-1:0]     plic_me_int,
    input  logic [CORE_NUM-1:0]     plic_se_int,
    input  logic [CORE_NUM-1:0]     pad_dbgrq_b,
    input  logic [CORE_NUM-1:0]     pad_dbg_mask,
    input  logic [2*CORE_NUM-1:0]   piu_sysio_lpmd_b,
    input  logic [2*CORE_NUM-1:0]   piu_sysio_jdb_pm,
    output logic [CORE_NUM-1:0]     sysio_piu_ms_int,
    output logic [CORE_NUM-1:0]     sysio_piu_mt_int,
    output logic [CORE_NUM-1:0]     sysio_piu_ss_int,
    output logic [CORE_NUM-1:0]     sysio_piu_st_int,
    output logic [CORE_NUM-1:0]     sysio_piu_me_int,
    output logic [CORE_NUM-1:0]     sysio_piu_se_int,
    output logic [CORE_NUM-1:0]     sysio_piu_dbgrq_b,
    output logic [CORE_NUM-1:0]     sysio_had_dbg_mask,
    output logic [2*CORE_NUM-1:0]   core_pad_lpmd_b,
    output logic [2*CORE_NUM-1:0]   core_pad_jdb_pm,
    output logic [8*CORE_NUM-1:0]   core_lpmd_cnt,
    output logic                    sysio_l2c_flush_req,
    output logic                    cpu_pad_l2cache_flush_done,
    output logic                    cpu_pad_no_op,
    output logic [CNT_W-1:0]        sysio_xx_time,
    output logic [CNT_W-1:0]        sysio_clint_mtime,
    output logic                    sysio_time_updt,
    output logic [39:0]             sysio_xx_apb_base,
    output logic [1:0]              sysio_dbg_flush_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DONE      = 2'd3
    } flush_state_e;

    // Only the upper APB_HI bits survive; the rest are constant zero.
    localparam logic [39:0] APB_MASK = ~((40'd1 << (40 - APB_HI)) - 40'd1);

    flush_state_e            state_q, state_d;
    logic [CORE_NUM-1:0]     ms_q, mt_q, ss_q, st_q, me_q, se_q;
    logic [CORE_NUM-1:0]     dbgrq_b_q, dbg_mask_q;
    logic [2*CORE_NUM-1:0]   lpmd_b_q, jdb_pm_q;
    logic [8*CORE_NUM-1:0]   cnt_q, cnt_d;
    logic                    no_op_q, no_op_d;
    logic [CNT_W-1:0]        time_q, time_d;
    logic                    updt_q, updt_d;
    logic [39:0]             apb_q;
    logic                    time_ge;

    always_comb begin
        state_d = state_q;
        if (axim_clk_en) begin
            case (state_q)
                ST_IDLE:      if (pad_cpu_l2cache_flush_req) state_d = ST_REQ;
                ST_REQ:       state_d = ST_WAIT_DONE;
                ST_WAIT_DONE: if (l2c_sysio_flush_done) state_d = ST_DONE;
                ST_DONE:      if (!pad_cpu_l2cache_flush_req) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < CORE_NUM; k++) begin
            // Entry edge: previously fully awake, now any other mode; saturates at 255.
            if ((lpmd_b_q[2*k +: 2] == 2'b11) && (piu_sysio_lpmd_b[2*k +: 2] != 2'b11)
                && (cnt_q[8*k +: 8] != 8'hFF)) begin
                cnt_d[8*k +: 8] = cnt_q[8*k +: 8] + 8'd1;
            end
        end
    end

    always_comb begin
        no_op_d = ciu_xx_no_op & l2c_sysio_flush_idle & (state_q == ST_IDLE);
        time_ge = (pad_cpu_sys_cnt >= time_q);
        time_d  = time_q;
        updt_d  = 1'b0;
        if (axim_clk_en && time_ge) begin
            time_d = pad_cpu_sys_cnt;
            updt_d = (pad_cpu_sys_cnt != time_q);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q    <= ST_IDLE;
            ms_q       <= '0;
            mt_q       <= '0;
            ss_q       <= '0;
            st_q       <= '0;
            me_q       <= '0;
            se_q       <= '0;
            dbgrq_b_q  <= '1;
            dbg_mask_q <= '0;
            lpmd_b_q   <= '1;
            jdb_pm_q   <= '0;
            cnt_q      <= '0;
            no_op_q    <= 1'b0;
            time_q     <= '0;
            updt_q     <= 1'b0;
            apb_q      <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            // The update pulse is cleared on every non-strobe cycle.
            updt_q  <= updt_d;
            if (axim_clk_en) begin
                ms_q       <= clint_ms_int;
                mt_q       <= clint_mt_int;
                ss_q       <= clint_ss_int;
                st_q       <= clint_st_int;
                me_q       <= plic_me_int;
                se_q       <= plic_se_int;
                dbgrq_b_q  <= pad_dbgrq_b;
                dbg_mask_q <= pad_dbg_mask;
                lpmd_b_q   <= piu_sysio_lpmd_b;
                jdb_pm_q   <= piu_sysio_jdb_pm;
                cnt_q      <= cnt_d;
                no_op_q    <= no_op_d;
                apb_q      <= pad_cpu_apb_base & APB_MASK;
            end
        end
    end

    assign sysio_piu_ms_int           = ms_q;
    assign sysio_piu_mt_int           = mt_q;
    assign sysio_piu_ss_int           = ss_q;
    assign sysio_piu_st_int           = st_q;
    assign sysio_piu_me_int           = me_q;
    assign sysio_piu_se_int           = se_q;
    assign sysio_piu_dbgrq_b          = dbgrq_b_q;
    assign sysio_had_dbg_mask         = dbg_mask_q;
    assign core_pad_lpmd_b            = lpmd_b_q;
    assign core_pad_jdb_pm            = jdb_pm_q;
    assign core_lpmd_cnt              = cnt_q;
    assign sysio_l2c_flush_req        = (state_q == ST_REQ) || (state_q == ST_WAIT_DONE);
    assign cpu_pad_l2cache_flush_done = (state_q == ST_DONE);
    assign cpu_pad_no_op              = no_op_q;
    assign sysio_xx_time              = time_q;
    assign sysio_clint_mtime          = time_q;
    assign sysio_time_updt            = updt_q;
    assign sysio_xx_apb_base          = apb_q;
    assign sysio_dbg_flush_state      = state_q;

endmodule

// File: tb/tb_ct_sysio_mcore.sv
// Directed bench for ct_sysio_mcore: expected values are queued before each strobe
// and popped against DUT outputs one cycle after the sampling edge.
module tb_ct_sysio_mcore;

    localparam int CN = 4;
    localparam int CW = 64;

    logic              clk;
    logic              cpurst;
    logic              axim_clk_en;
    logic [CW-1:0]     pad_cpu_sys_cnt;
    logic [39:0]       pad_cpu_apb_base;
    logic              pad_cpu_l2cache_flush_req;
    logic              l2c_sysio_flush_done;
    logic              l2c_sysio_flush_idle;
    logic              ciu_xx_no_op;
    logic [CN-1:0]     clint_ms_int, clint_mt_int, clint_ss_int, clint_st_int;
    logic [CN-1:0]     plic_me_int, plic_se_int;
    logic [CN-1:0]     pad_dbgrq_b, pad_dbg_mask;
    logic [2*CN-1:0]   piu_sysio_lpmd_b, piu_sysio_jdb_pm;
    logic [CN-1:0]     sysio_piu_ms_int, sysio_piu_mt_int, sysio_piu_ss_int, sysio_piu_st_int;
    logic [CN-1:0]     sysio_piu_me_int, sysio_piu_se_int;
    logic [CN-1:0]     sysio_piu_dbgrq_b, sysio_had_dbg_mask;
    logic [2*CN-1:0]   core_pad_lpmd_b, core_pad_jdb_pm;
    logic [8*CN-1:0]   core_lpmd_cnt;
    logic              sysio_l2c_flush_req, cpu_pad_l2cache_flush_done, cpu_pad_no_op;
    logic [CW-1:0]     sysio_xx_time, sysio_clint_mtime;
    logic              sysio_time_updt;
    logic [39:0]       sysio_xx_apb_base;
    logic [1:0]        sysio_dbg_flush_state;

    logic [63:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    ct_sysio_mcore #(.CORE_NUM(CN), .CNT_W(CW), .APB_HI(13)) dut (
        .forever_cpuclk             (clk),
        .cpurst                     (cpurst),
        .axim_clk_en                (axim_clk_en),
        .pad_cpu_sys_cnt            (pad_cpu_sys_cnt),
        .pad_cpu_apb_base           (pad_cpu_apb_base),
        .pad_cpu_l2cache_flush_req  (pad_cpu_l2cache_flush_req),
        .l2c_sysio_flush_done       (l2c_sysio_flush_done),
        .l2c_sysio_flush_idle       (l2c_sysio_flush_idle),
        .ciu_xx_no_op               (ciu_xx_no_op),
        .clint_ms_int               (clint_ms_int),
        .clint_mt_int               (clint_mt_int),
        .clint_ss_int               (clint_ss_int),
        .clint_st_int               (clint_st_int),
        .plic_me_int                (plic_me_int),
        .plic_se_int                (plic_se_int),
        .pad_dbgrq_b                (pad_dbgrq_b),
        .pad_dbg_mask               (pad_dbg_mask),
        .piu_sysio_lpmd_b           (piu_sysio_lpmd_b),
        .piu_sysio_jdb_pm           (piu_sysio_jdb_pm),
        .sysio_piu_ms_int           (sysio_piu_ms_int),
        .sysio_piu_mt_int           (sysio_piu_mt_int),
        .sysio_piu_ss_int           (sysio_piu_ss_int),
        .sysio_piu_st_int           (sysio_piu_st_int),
        .sysio_piu_me_int           (sysio_piu_me_int),
        .sysio_piu_se_int           (sysio_piu_se_int),
        .sysio_piu_dbgrq_b          (sysio_piu_dbgrq_b),
        .sysio_had_dbg_mask         (sysio_had_dbg_mask),
        .core_pad_lpmd_b            (core_pad_lpmd_b),
        .core_pad_jdb_pm            (core_pad_jdb_pm),
        .core_lpmd_cnt              (core_lpmd_cnt),
        .sysio_l2c_flush_req        (sysio_l2c_flush_req),
        .cpu_pad_l2cache_flush_done (cpu_pad_l2cache_flush_done),
        .cpu_pad_no_op              (cpu_pad_no_op),
        .sysio_xx_time              (sysio_xx_time),
        .sysio_clint_mtime          (sysio_clint_mtime),
        .sysio_time_updt            (sysio_time_updt),
        .sysio_xx_apb_base          (sysio_xx_apb_base),
        .sysio_dbg_flush_state      (sysio_dbg_flush_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic strobe();
        axim_clk_en = 1'b1;
        @(posedge clk);
        #1;
        axim_clk_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flush(input string tag, input logic [1:0] st, input logic req, input logic done);
        push({62'd0, st});
        push({63'd0, req});
        push({63'd0, done});
        chk({tag, "_state"}, {62'd0, sysio_dbg_flush_state});
        chk({tag, "_req"}, {63'd0, sysio_l2c_flush_req});
        chk({tag, "_done"}, {63'd0, cpu_pad_l2cache_flush_done});
    endtask

    task automatic chk_reset_values(input string tag);
        push(64'd0);         chk({tag, "_mt_int"},  {60'd0, sysio_piu_mt_int});
        push(64'd0);         chk({tag, "_me_int"},  {60'd0, sysio_piu_me_int});
        push(64'hF);         chk({tag, "_dbgrq_b"}, {60'd0, sysio_piu_dbgrq_b});
        push(64'd0);         chk({tag, "_dbgmask"}, {60'd0, sysio_had_dbg_mask});
        push(64'hFF);        chk({tag, "_lpmd_b"},  {56'd0, core_pad_lpmd_b});
        push(64'd0);         chk({tag, "_jdb_pm"},  {56'd0, core_pad_jdb_pm});
        push(64'd0);         chk({tag, "_lpcnt"},   {32'd0, core_lpmd_cnt});
        push(64'd0);         chk({tag, "_no_op"},   {63'd0, cpu_pad_no_op});
        push(64'd0);         chk({tag, "_time"},    sysio_xx_time);
        push(64'd0);         chk({tag, "_mtime"},   sysio_clint_mtime);
        push(64'd0);         chk({tag, "_updt"},    {63'd0, sysio_time_updt});
        push(64'd0);         chk({tag, "_apb"},     {24'd0, sysio_xx_apb_base});
        chk_flush(tag, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] tseq [6];
        logic [63:0] texp [6];
        logic        tupd [6];
        logic [7:0]  model_cnt;

        tseq = '{64'd100, 64'd105, 64'd103, 64'd105, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        texp = '{64'd100, 64'd105, 64'd105, 64'd105, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        tupd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        cpurst = 1'b1;
        axim_clk_en = 1'b0;
        pad_cpu_sys_cnt = '0;
        pad_cpu_apb_base = '0;
        pad_cpu_l2cache_flush_req = 1'b0;
        l2c_sysio_flush_done = 1'b0;
        l2c_sysio_flush_idle = 1'b1;
        ciu_xx_no_op = 1'b1;
        clint_ms_int = '0; clint_mt_int = '0; clint_ss_int = '0; clint_st_int = '0;
        plic_me_int = '0; plic_se_int = '0;
        pad_dbgrq_b = '1;
        pad_dbg_mask = '0;
        piu_sysio_lpmd_b = '1;
        piu_sysio_jdb_pm = '0;
        idle_cycle();
        idle_cycle();
        // Reset together with a strobe and busy inputs: reset must win.
        clint_mt_int = 4'hF;
        pad_dbgrq_b = 4'h0;
        pad_cpu_sys_cnt = 64'd77;
        strobe();
        cpurst = 1'b0;
        clint_mt_int = '0;
        pad_dbgrq_b = '1;
        pad_cpu_sys_cnt = '0;
        chk_reset_values("rst");

        // Forwarding with a strobe every second cycle.
        clint_mt_int = 4'b1010;
        plic_me_int = 4'b0001;
        pad_dbgrq_b = 4'b0110;
        pad_dbg_mask = 4'b0011;
        piu_sysio_jdb_pm = 8'h5A;
        pad_cpu_apb_base = 40'hAB_CDEF_1234;
        strobe();
        push(64'hA);            chk("fwd_mt", {60'd0, sysio_piu_mt_int});
        push(64'h1);            chk("fwd_me", {60'd0, sysio_piu_me_int});
        push(64'h6);            chk("fwd_dbgrq", {60'd0, sysio_piu_dbgrq_b});
        push(64'h3);            chk("fwd_mask", {60'd0, sysio_had_dbg_mask});
        push(64'h5A);           chk("fwd_jdb", {56'd0, core_pad_jdb_pm});
        push(64'hAB_C800_0000); chk("fwd_apb", {24'd0, sysio_xx_apb_base});
        push(64'd1);            chk("fwd_no_op", {63'd0, cpu_pad_no_op});
        clint_mt_int = 4'b0101;
        idle_cycle();
        push(64'hA);            chk("hold_mt", {60'd0, sysio_piu_mt_int});
        strobe();
        push(64'h5);            chk("fwd_mt2", {60'd0, sysio_piu_mt_int});
        idle_cycle();

        // Time guard: backwards values and the all-ones-to-zero wrap are held.
        for (int i = 0; i < 6; i++) begin
            pad_cpu_sys_cnt = tseq[i];
            strobe();
            push(texp[i]);         chk("time", sysio_xx_time);
            push(texp[i]);         chk("mtime", sysio_clint_mtime);
            push({63'd0, tupd[i]}); chk("updt", {63'd0, sysio_time_updt});
            idle_cycle();
            push(texp[i]);         chk("time_hold", sysio_xx_time);
            push(64'd0);           chk("updt_nostrobe", {63'd0, sysio_time_updt});
        end

        // Done level in IDLE is ignored.
        l2c_sysio_flush_done = 1'b1;
        strobe();
        chk_flush("done_in_idle", 2'd0, 1'b0, 1'b0);
        l2c_sysio_flush_done = 1'b0;

        // Full flush handshake.
        pad_cpu_l2cache_flush_req = 1'b1;
        strobe();
        chk_flush("fl_req", 2'd1, 1'b1, 1'b0);
        idle_cycle();
        chk_flush("fl_req_hold", 2'd1, 1'b1, 1'b0);
        strobe();
        chk_flush("fl_wait", 2'd2, 1'b1, 1'b0);
        push(64'd0);  chk("fl_no_op_wait", {63'd0, cpu_pad_no_op});
        strobe();
        chk_flush("fl_wait2", 2'd2, 1'b1, 1'b0);
        l2c_sysio_flush_done = 1'b1;
        strobe();
        chk_flush("fl_done", 2'd3, 1'b0, 1'b1);
        push(64'd0);  chk("fl_no_op_done", {63'd0, cpu_pad_no_op});
        l2c_sysio_flush_done = 1'b0;
        strobe();
        chk_flush("fl_done_hold", 2'd3, 1'b0, 1'b1);
        pad_cpu_l2cache_flush_req = 1'b0;
        strobe();
        chk_flush("fl_idle", 2'd0, 1'b0, 1'b0);
        strobe();
        push(64'd1);  chk("fl_no_op_idle", {63'd0, cpu_pad_no_op});

        // Done level during REQ is ignored; REQ always advances to WAIT_DONE.
        pad_cpu_l2cache_flush_req = 1'b1;
        l2c_sysio_flush_done = 1'b1;
        strobe();
        chk_flush("req_done_ign", 2'd1, 1'b1, 1'b0);
        strobe();
        chk_flush("req_to_wait", 2'd2, 1'b1, 1'b0);
        strobe();
        chk_flush("req_to_done", 2'd3, 1'b0, 1'b1);
        pad_cpu_l2cache_flush_req = 1'b0;
        l2c_sysio_flush_done = 1'b0;
        strobe();
        chk_flush("req_back_idle", 2'd0, 1'b0, 1'b0);

        // Early request drop in WAIT_DONE.
        pad_cpu_l2cache_flush_req = 1'b1;
        strobe();
        strobe();
        chk_flush("ed_wait", 2'd2, 1'b1, 1'b0);
        pad_cpu_l2cache_flush_req = 1'b0;
        strobe();
        chk_flush("ed_wait_dropped", 2'd2, 1'b1, 1'b0);
        l2c_sysio_flush_done = 1'b1;
        strobe();
        chk_flush("ed_done_pulse", 2'd3, 1'b0, 1'b1);
        l2c_sysio_flush_done = 1'b0;
        strobe();
        chk_flush("ed_idle", 2'd0, 1'b0, 1'b0);

        // Low-power entries on core 2, saturating at 255.
        model_cnt = 8'd0;
        for (int n = 0; n < 300; n++) begin
            piu_sysio_lpmd_b = 8'hDF;
            strobe();
            model_cnt = (model_cnt == 8'hFF) ? 8'hFF : model_cnt + 8'd1;
            piu_sysio_lpmd_b = 8'hFF;
            strobe();
            if (n == 9 || n == 299) begin
                push({32'd0, 8'd0, model_cnt, 16'd0});
                chk("lpcnt", {32'd0, core_lpmd_cnt});
            end
        end
        push(64'hFF);  chk("lpmd_b_fwd", {56'd0, core_pad_lpmd_b});

        // Reset mid-flush with a strobe in the same cycle.
        pad_cpu_l2cache_flush_req = 1'b1;
        strobe();
        strobe();
        chk_flush("mid_wait", 2'd2, 1'b1, 1'b0);
        cpurst = 1'b1;
        clint_mt_int = 4'hF;
        plic_me_int = 4'hF;
        pad_dbgrq_b = 4'h0;
        pad_dbg_mask = 4'hF;
        pad_cpu_sys_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        strobe();
        cpurst = 1'b0;
        pad_cpu_l2cache_flush_req = 1'b0;
        chk_reset_values("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
